// File: rtl/iomem_timer.sv
// iomem_timer
// -----------
// Memory-mapped 32-bit down-counting timer for the PicoSoC iomem bus.
// It has a 16-bit prescaler, one-shot and auto-reload modes, and a
// level interrupt.
//
// Register map (byte offsets inside the BASE_ADDR slot):
//   0x00 CTRL      bit0 en, bit1 auto, bit2 irq_en
//   0x04 PRESCALE  bits[15:0]; one tick every PRESCALE+1 enabled cycles
//   0x08 COUNT     current counter value
//   0x0C RELOAD    value loaded into COUNT on an auto-reload expiry
//   0x10 STATUS    bit0 expired; writing 1 clears it
//   0x14-0x1C      read as zero; writes are ignored but acknowledged
//
// Ports:
//   clk          system clock
//   resetn       synchronous active-low reset
//   iomem_valid  bus request valid
//   iomem_ready  one-cycle acknowledge for a selected request
//   iomem_wstrb  byte write strobes; 0 means a read
//   iomem_addr   byte address; [31:24] selects the block, [4:2] the register
//   iomem_wdata  write data
//   iomem_rdata  read data, valid while iomem_ready is high
//   irq          level interrupt = STATUS.expired & CTRL.irq_en
module iomem_timer #(
    parameter logic [7:0] BASE_ADDR = 8'h05
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        iomem_valid,
    output logic        iomem_ready,
    input  logic [3:0]  iomem_wstrb,
    input  logic [31:0] iomem_addr,
    input  logic [31:0] iomem_wdata,
    output logic [31:0] iomem_rdata,
    output logic        irq
);

    typedef enum logic [2:0] {
        REG_CTRL     = 3'd0,
        REG_PRESCALE = 3'd1,
        REG_COUNT    = 3'd2,
        REG_RELOAD   = 3'd3,
        REG_STATUS   = 3'd4
    } reg_idx_e;

    // Architectural state
    logic        r_en;
    logic        r_auto;
    logic        r_irq_en;
    logic [15:0] r_prescale;
    logic [31:0] r_count;
    logic [31:0] r_reload;
    logic        r_expired;
    logic [15:0] r_pcnt;
    logic        r_ready;
    logic [31:0] r_rdata;

    // Decode and datapath wires
    reg_idx_e    w_idx;
    logic        w_sel;
    logic        w_wr;
    logic        w_wr_ctrl;
    logic        w_wr_prescale;
    logic        w_wr_count;
    logic        w_wr_reload;
    logic        w_wr_status;
    logic        w_tick;
    logic        w_expire;
    logic [31:0] w_rd_mux;
    logic        w_unused_addr;

    // Byte-lane merge: each strobe bit independently replaces one byte.
    function automatic logic [31:0] f_merge(input logic [31:0] old_val,
                                            input logic [31:0] new_val,
                                            input logic [3:0]  strb);
        logic [31:0] res;
        for (int b = 0; b < 4; b++) begin
            res[8*b +: 8] = strb[b] ? new_val[8*b +: 8] : old_val[8*b +: 8];
        end
        return res;
    endfunction

    // Gating on !r_ready keeps ready from rising on back-to-back cycles
    // while the master still holds valid during the acknowledge cycle.
    assign w_sel = iomem_valid && !r_ready && (iomem_addr[31:24] == BASE_ADDR);
    assign w_idx = reg_idx_e'(iomem_addr[4:2]);
    assign w_wr  = w_sel && (iomem_wstrb != 4'b0000);

    assign w_wr_ctrl     = w_wr && (w_idx == REG_CTRL);
    assign w_wr_prescale = w_wr && (w_idx == REG_PRESCALE);
    assign w_wr_count    = w_wr && (w_idx == REG_COUNT);
    assign w_wr_reload   = w_wr && (w_idx == REG_RELOAD);
    assign w_wr_status   = w_wr && (w_idx == REG_STATUS);

    assign w_tick   = r_en && (r_pcnt == r_prescale);
    assign w_expire = w_tick && (r_count == 32'd1);

    // Address bits between the slot select and the register index are don't-care.
    assign w_unused_addr = ^{iomem_addr[23:5], iomem_addr[1:0]};

    // Read mux always sees the pre-write register values.
    always_comb begin
        // NOTE: default first so every path assigns w_rd_mux and no latch is inferred.
        w_rd_mux = '0;
        case (w_idx)
            REG_CTRL:     w_rd_mux = {29'd0, r_irq_en, r_auto, r_en};
            REG_PRESCALE: w_rd_mux = {16'd0, r_prescale};
            REG_COUNT:    w_rd_mux = r_count;
            REG_RELOAD:   w_rd_mux = r_reload;
            REG_STATUS:   w_rd_mux = {31'd0, r_expired};
            default:      w_rd_mux = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_en       <= 1'b0;
            r_auto     <= 1'b0;
            r_irq_en   <= 1'b0;
            r_prescale <= '0;
            r_count    <= '0;
            r_reload   <= '0;
            r_expired  <= 1'b0;
            r_pcnt     <= '0;
            r_ready    <= 1'b0;
            r_rdata    <= '0;
        end else begin
            r_ready <= w_sel;
            r_rdata <= w_sel ? w_rd_mux : '0;

            // Prescaler: held at 0 while disabled, restarts on tick or PRESCALE write.
            if (!r_en || w_tick || w_wr_prescale) begin
                r_pcnt <= '0;
            end else begin
                r_pcnt <= r_pcnt + 16'd1;
            end

            // Hardware counter update. COUNT==0 simply holds.
            if (w_tick && (r_count > 32'd1)) begin
                r_count <= r_count - 32'd1;
            end else if (w_expire) begin
                r_count <= r_auto ? r_reload : 32'd0;
            end
            if (w_expire && !r_auto) begin
                r_en <= 1'b0;
            end

            // NOTE: of several nonblocking assignments to one register in a
            // block, the last one wins; bus writes below override the
            // hardware updates above, which sets the collision priority.
            if (w_wr_count) begin
                r_count <= f_merge(r_count, iomem_wdata, iomem_wstrb);
            end
            if (w_wr_ctrl && iomem_wstrb[0]) begin
                r_en     <= iomem_wdata[0];
                r_auto   <= iomem_wdata[1];
                r_irq_en <= iomem_wdata[2];
            end
            if (w_wr_prescale) begin
                if (iomem_wstrb[0]) r_prescale[7:0]  <= iomem_wdata[7:0];
                if (iomem_wstrb[1]) r_prescale[15:8] <= iomem_wdata[15:8];
            end
            if (w_wr_reload) begin
                r_reload <= f_merge(r_reload, iomem_wdata, iomem_wstrb);
            end

            // Expiry set is placed after the clear so it wins a same-edge collision.
            if (w_wr_status && iomem_wstrb[0] && iomem_wdata[0]) begin
                r_expired <= 1'b0;
            end
            if (w_expire) begin
                r_expired <= 1'b1;
            end
        end
    end

    assign iomem_ready = r_ready;
    assign iomem_rdata = r_rdata;
    assign irq         = r_expired & r_irq_en;

endmodule

// File: tb/tb_iomem_timer.sv
// Directed testbench for iomem_timer: reset state, bus handshake, one-shot
// and auto-reload timing, byte lanes, same-edge collisions and mid-count reset.
module tb_iomem_timer;

    localparam logic [31:0] BASE     = 32'h0500_0000;
    localparam logic [31:0] A_CTRL   = BASE + 32'h00;
    localparam logic [31:0] A_PRESC  = BASE + 32'h04;
    localparam logic [31:0] A_COUNT  = BASE + 32'h08;
    localparam logic [31:0] A_RELOAD = BASE + 32'h0C;
    localparam logic [31:0] A_STATUS = BASE + 32'h10;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        iomem_valid = 1'b0;
    logic        iomem_ready;
    logic [3:0]  iomem_wstrb = 4'b0000;
    logic [31:0] iomem_addr = '0;
    logic [31:0] iomem_wdata = '0;
    logic [31:0] iomem_rdata;
    logic        irq;

    int n_pass  = 0;
    int n_total = 0;
    int cyc     = 0;

    iomem_timer #(.BASE_ADDR(8'h05)) dut (
        .clk         (clk),
        .resetn      (resetn),
        .iomem_valid (iomem_valid),
        .iomem_ready (iomem_ready),
        .iomem_wstrb (iomem_wstrb),
        .iomem_addr  (iomem_addr),
        .iomem_wdata (iomem_wdata),
        .iomem_rdata (iomem_rdata),
        .irq         (irq)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // One bus access. The register effect lands at the edge that raises
    // ready (Ew); the task returns 1 time unit after Ew+1.
    task automatic bus(input logic [31:0] addr, input logic [3:0] strb,
                       input logic [31:0] wdata, output logic [31:0] rdata);
        @(negedge clk);
        iomem_addr  = addr;
        iomem_wstrb = strb;
        iomem_wdata = wdata;
        iomem_valid = 1'b1;
        @(posedge clk);
        #1;
        check($sformatf("ready_hi@%08h", addr), {31'd0, iomem_ready}, 32'd1);
        rdata = iomem_rdata;
        iomem_valid = 1'b0;
        iomem_wstrb = 4'b0000;
        @(posedge clk);
        #1;
        check($sformatf("ready_lo@%08h", addr), {31'd0, iomem_ready}, 32'd0);
    endtask

    task automatic wr(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb = 4'hF);
        logic [31:0] dummy;
        bus(addr, strb, data, dummy);
    endtask

    task automatic rd_check(input string tag, input logic [31:0] addr, input logic [31:0] exp);
        logic [31:0] val;
        bus(addr, 4'b0000, 32'd0, val);
        check(tag, val, exp);
    endtask

    // Waits up to budget edges for irq; stamp is the cycle count of the edge it rose on.
    task automatic wait_irq(input int budget, output int stamp, output logic ok);
        ok = 1'b0;
        stamp = 0;
        for (int i = 0; i < budget && !ok; i++) begin
            @(posedge clk);
            #1;
            if (irq) begin
                ok = 1'b1;
                stamp = cyc;
            end
        end
    endtask

    initial begin
        #200_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int          t0, e1, e2, e3, highs;
        logic        ok;

        // ---------------- reset ----------------
        resetn = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        check("rst_ready", {31'd0, iomem_ready}, 32'd0);
        check("rst_rdata", iomem_rdata, 32'd0);
        check("rst_irq", {31'd0, irq}, 32'd0);
        @(negedge clk);
        resetn = 1'b1;

        for (int off = 0; off < 32; off += 4) begin
            rd_check($sformatf("rst_rd_%02h", off), BASE + off, 32'd0);
        end

        // Unselected slot never acknowledges.
        @(negedge clk);
        iomem_addr  = 32'h0600_0008;
        iomem_wstrb = 4'b0000;
        iomem_valid = 1'b1;
        highs = 0;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk);
            #1;
            if (iomem_ready) highs++;
        end
        iomem_valid = 1'b0;
        check("unsel_ready", highs, 32'd0);

        // Unused offsets ignore writes but still acknowledge.
        wr(BASE + 32'h18, 32'hFFFF_FFFF);
        rd_check("unused_rd", BASE + 32'h18, 32'd0);
        rd_check("unused_ctrl", A_CTRL, 32'd0);

        // ---------------- one-shot ----------------
        // CTRL written at E0: ticks at E1 (3->2), E2 (2->1), E3 expiry.
        wr(A_PRESC, 32'd0);
        wr(A_COUNT, 32'd3);
        wr(A_CTRL, 32'h5);          // returns at E1
        @(posedge clk);
        #1;                          // after E2
        check("os_not_yet", {31'd0, dut.irq}, 32'd0);
        @(posedge clk);
        #1;                          // after E3
        check("os_irq", {31'd0, irq}, 32'd1);
        rd_check("os_count", A_COUNT, 32'd0);
        rd_check("os_ctrl", A_CTRL, 32'h4);
        rd_check("os_status", A_STATUS, 32'd1);
        wr(A_STATUS, 32'd1);
        check("os_irq_clr", {31'd0, irq}, 32'd0);

        // ---------------- auto-reload ----------------
        // Period = RELOAD*(PRESCALE+1) = 5*4 = 20 cycles. First expiry is also
        // 20 edges after the CTRL write edge; t0 is sampled one edge later, so 19.
        wr(A_PRESC, 32'd3);
        wr(A_RELOAD, 32'd5);
        wr(A_COUNT, 32'd5);
        wr(A_CTRL, 32'h7);
        t0 = cyc;
        wait_irq(40, e1, ok);
        check("ar_ev1_seen", {31'd0, ok}, 32'd1);
        check("ar_first", e1 - t0, 32'd19);
        wr(A_STATUS, 32'd1);
        wait_irq(40, e2, ok);
        check("ar_ev2_seen", {31'd0, ok}, 32'd1);
        check("ar_period1", e2 - e1, 32'd20);
        wr(A_STATUS, 32'd1);
        wait_irq(40, e3, ok);
        check("ar_ev3_seen", {31'd0, ok}, 32'd1);
        check("ar_period2", e3 - e2, 32'd20);
        wr(A_CTRL, 32'h0);
        wr(A_STATUS, 32'd1);
        rd_check("ar_status_clr", A_STATUS, 32'd0);

        // ---------------- byte lanes ----------------
        wr(A_RELOAD, 32'd0);
        wr(A_RELOAD, 32'hAABB_CCDD, 4'b0101);
        rd_check("bl_reload", A_RELOAD, 32'h00BB_00DD);
        wr(A_PRESC, 32'hFFFF_FFFF);
        rd_check("bl_presc", A_PRESC, 32'h0000_FFFF);
        wr(A_CTRL, 32'hFFFF_FFFF, 4'b1110);
        rd_check("bl_ctrl_nolane0", A_CTRL, 32'd0);
        wr(A_PRESC, 32'd0);

        // ---------------- collision: STATUS clear vs expiry ----------------
        // CTRL write at E0, expiry at E4; the STATUS write is aimed at E4.
        wr(A_COUNT, 32'd4);
        wr(A_CTRL, 32'h1);          // returns after E1
        repeat (2) @(posedge clk);   // at E3
        wr(A_STATUS, 32'd1);         // write edge E4
        rd_check("col_status", A_STATUS, 32'd1);
        rd_check("col_ctrl_hwclr", A_CTRL, 32'd0);
        rd_check("col_count0", A_COUNT, 32'd0);
        wr(A_STATUS, 32'd1);
        rd_check("col_status_clr", A_STATUS, 32'd0);

        // ---------------- collision: CTRL.en write vs hardware clear ----------------
        wr(A_COUNT, 32'd4);
        wr(A_CTRL, 32'h1);
        repeat (2) @(posedge clk);
        wr(A_CTRL, 32'h1);           // lands on the expiry edge
        rd_check("col_en_kept", A_CTRL, 32'h1);
        rd_check("col_en_status", A_STATUS, 32'd1);
        wr(A_CTRL, 32'h0);
        wr(A_STATUS, 32'd1);

        // ---------------- collision: COUNT write vs tick ----------------
        // PRESCALE=0, so every enabled edge ticks. COUNT=9 written at E2 (a
        // tick edge), one more tick at E3 gives 8, seen by the read at E4.
        wr(A_COUNT, 32'd50);
        wr(A_CTRL, 32'h1);           // write edge E0, returns after E1
        wr(A_COUNT, 32'd9);          // write edge E2, returns after E3
        rd_check("col_count_wr", A_COUNT, 32'd8);
        wr(A_CTRL, 32'h0);

        // ---------------- reset mid-operation ----------------
        wr(A_PRESC, 32'd2);
        wr(A_COUNT, 32'd100);
        wr(A_CTRL, 32'h5);
        repeat (30) @(posedge clk);
        @(negedge clk);
        resetn = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("mrst_ready", {31'd0, iomem_ready}, 32'd0);
        check("mrst_irq", {31'd0, irq}, 32'd0);
        @(negedge clk);
        resetn = 1'b1;
        rd_check("mrst_ctrl", A_CTRL, 32'd0);
        rd_check("mrst_presc", A_PRESC, 32'd0);
        rd_check("mrst_count", A_COUNT, 32'd0);
        rd_check("mrst_reload", A_RELOAD, 32'd0);
        rd_check("mrst_status", A_STATUS, 32'd0);
        highs = 0;
        for (int i = 0; i < 500; i++) begin
            @(posedge clk);
            #1;
            if (irq) highs++;
        end
        check("mrst_no_irq", highs, 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
